// File: rtl/sfp_pkg.sv
// Shared codes and defaults for the vectorised special-function pipe.
package sfp_pkg;

  localparam int PSUM_BW_DEF = 16;

  typedef enum logic [1:0] {
    SFP_PASS    = 2'b00,
    SFP_ACC     = 2'b01,
    SFP_ACT     = 2'b10,
    SFP_ACC_ACT = 2'b11
  } sfp_mode_e;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'b00,
    ACT_RELU  = 2'b01,
    ACT_LEAKY = 2'b10,
    ACT_RSVD  = 2'b11
  } act_sel_e;

endpackage

// File: rtl/sfp_lane.sv
// One lane of the special-function pipe: combinational add/saturate for stage 1
// and the activation function for stage 2.
module sfp_lane
  import sfp_pkg::*;
#(
  parameter int PSUM_BW     = PSUM_BW_DEF,
  parameter int LEAKY_SHIFT = 6
) (
  input  logic signed [PSUM_BW-1:0] psum,
  input  logic signed [PSUM_BW-1:0] ofifo,
  input  sfp_mode_e                 mode,
  input  logic                      sat_en,
  output logic signed [PSUM_BW-1:0] s1_res,
  output logic                      s1_ovf,
  input  logic signed [PSUM_BW-1:0] act_in,
  input  sfp_mode_e                 act_mode,
  input  act_sel_e                  act_sel,
  output logic signed [PSUM_BW-1:0] act_out
);

  localparam logic [PSUM_BW-1:0] SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic [PSUM_BW-1:0] SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

  logic [PSUM_BW:0] wide_sum;
  logic             add_ovf;

  // One extra bit lets overflow be read off the top two bits of the sum.
  assign wide_sum = {psum[PSUM_BW-1], psum} + {ofifo[PSUM_BW-1], ofifo};
  assign add_ovf  = wide_sum[PSUM_BW] ^ wide_sum[PSUM_BW-1];

  always_comb begin
    s1_res = ofifo;
    s1_ovf = 1'b0;
    case (mode)
      SFP_PASS: s1_res = ofifo;
      SFP_ACT:  s1_res = psum;
      default: begin
        s1_ovf = add_ovf;
        if (add_ovf && sat_en)
          s1_res = wide_sum[PSUM_BW] ? SAT_MIN : SAT_MAX;
        else
          s1_res = wide_sum[PSUM_BW-1:0];
      end
    endcase
  end

  // Activation applies only to the act modes; pass/acc ignore act_sel.
  always_comb begin
    act_out = act_in;
    if (act_mode == SFP_ACT || act_mode == SFP_ACC_ACT) begin
      case (act_sel)
        ACT_RELU:  if (act_in[PSUM_BW-1]) act_out = '0;
        ACT_LEAKY: if (act_in[PSUM_BW-1]) act_out = act_in >>> LEAKY_SHIFT;
        default:   act_out = act_in;
      endcase
    end
  end

endmodule

// File: rtl/sfp_vec_pipe.sv
// Two-stage valid/ready special-function pipe over COL lanes: S1 add/select,
// S2 activation feeding sfp_out, plus sticky overflow flags and a beat counter.
module sfp_vec_pipe
  import sfp_pkg::*;
#(
  parameter int COL         = 8,
  parameter int PSUM_BW     = PSUM_BW_DEF,
  parameter int LEAKY_SHIFT = 6,
  parameter int CNT_BW      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COL*PSUM_BW-1:0] psum_in,
  input  logic [COL*PSUM_BW-1:0] ofifo_in,
  input  logic [1:0]             mode,
  input  logic [1:0]             act_sel,
  input  logic                   sat_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COL*PSUM_BW-1:0] sfp_out,
  output logic [COL-1:0]         ovf_flag,
  input  logic                   clr_flags,
  output logic [CNT_BW-1:0]      beat_cnt
);

  logic                   s1_valid;
  logic [COL*PSUM_BW-1:0] s1_data;
  logic [COL-1:0]         s1_ovf;
  sfp_mode_e              s1_mode;
  act_sel_e               s1_act_sel;

  logic [COL*PSUM_BW-1:0] s1_res;
  logic [COL-1:0]         s1_ovf_c;
  logic [COL*PSUM_BW-1:0] act_res;

  logic s2_ready;
  logic s1_advance;

  assign s2_ready   = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_ready;
  assign in_ready   = !s1_valid || s1_advance;

  for (genvar i = 0; i < COL; i++) begin : g_lane
    sfp_lane #(
      .PSUM_BW    (PSUM_BW),
      .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_lane (
      .psum    (psum_in[i*PSUM_BW +: PSUM_BW]),
      .ofifo   (ofifo_in[i*PSUM_BW +: PSUM_BW]),
      .mode    (sfp_mode_e'(mode)),
      .sat_en  (sat_en),
      .s1_res  (s1_res[i*PSUM_BW +: PSUM_BW]),
      .s1_ovf  (s1_ovf_c[i]),
      .act_in  (s1_data[i*PSUM_BW +: PSUM_BW]),
      .act_mode(s1_mode),
      .act_sel (s1_act_sel),
      .act_out (act_res[i*PSUM_BW +: PSUM_BW])
    );
  end

  // Control fields travel with the beat so later input changes cannot affect it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_ovf     <= '0;
      s1_mode    <= SFP_PASS;
      s1_act_sel <= ACT_NONE;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data    <= s1_res;
        s1_ovf     <= s1_ovf_c;
        s1_mode    <= sfp_mode_e'(mode);
        s1_act_sel <= act_sel_e'(act_sel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sfp_out   <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) sfp_out <= act_res;
    end
  end

  // A new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)
      ovf_flag <= '0;
    else
      ovf_flag <= (clr_flags ? '0 : ovf_flag) | (s1_advance ? s1_ovf : '0);
  end

  always_ff @(posedge clk) begin
    if (reset)
      beat_cnt <= '0;
    else if (out_valid && out_ready)
      beat_cnt <= beat_cnt + 1'b1;
  end

endmodule

// File: tb/tb_sfp_vec_pipe.sv
// Directed self-checking bench for sfp_vec_pipe with hand-computed expectations.
module tb_sfp_vec_pipe;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int CNT_BW  = 16;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [COL*PSUM_BW-1:0] psum_in;
  logic [COL*PSUM_BW-1:0] ofifo_in;
  logic [1:0]             mode;
  logic [1:0]             act_sel;
  logic                   sat_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [COL*PSUM_BW-1:0] sfp_out;
  logic [COL-1:0]         ovf_flag;
  logic                   clr_flags;
  logic [CNT_BW-1:0]      beat_cnt;

  int vec_cnt     = 0;
  int miscompares = 0;

  sfp_vec_pipe #(
    .COL(COL), .PSUM_BW(PSUM_BW), .LEAKY_SHIFT(6), .CNT_BW(CNT_BW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .psum_in(psum_in), .ofifo_in(ofifo_in),
    .mode(mode), .act_sel(act_sel), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .sfp_out(sfp_out), .ovf_flag(ovf_flag),
    .clr_flags(clr_flags), .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [COL*PSUM_BW-1:0] fill(input int v);
    logic [COL*PSUM_BW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
    return r;
  endfunction

  function automatic logic [COL*PSUM_BW-1:0] row_inc(input int base);
    logic [COL*PSUM_BW-1:0] r;
    int v;
    for (int i = 0; i < COL; i++) begin
      v = base + i;
      r[i*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] lane(input int i);
    return {16'h0, sfp_out[i*PSUM_BW +: PSUM_BW]};
  endfunction

  function automatic logic [31:0] lo16(input int v);
    return {16'h0, v[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [1:0] a, input logic s,
                               input int p, input int o);
    in_valid = 1'b1;
    mode     = m;
    act_sel  = a;
    sat_en   = s;
    psum_in  = fill(p);
    ofifo_in = fill(o);
  endtask

  task automatic doReset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    clr_flags = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Single beat with out_ready high: accept, two edges later the result is presented.
  task automatic doBeat(input logic [1:0] m, input logic [1:0] a, input logic s,
                        input int p, input int o, input int exp, input string tag);
    applyStimulus(m, a, s, p, o);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_l0"}, lane(0), lo16(exp));
    checkOutput({tag, "_l7"}, lane(COL-1), lo16(exp));
    @(negedge clk);
  endtask

  initial begin
    int idx;
    int oidx;
    logic saw_full;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    mode = 2'b00; act_sel = 2'b00; sat_en = 1'b0;
    psum_in = '0; ofifo_in = '0;
    doReset();

    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sfp_out", lane(0), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_flag), 32'd0);
    checkOutput("rst_cnt", 32'(beat_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic accumulate and two-cycle latency
    applyStimulus(2'b01, 2'b00, 1'b0, 100, -30);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("acc_valid", 32'(out_valid), 32'd1);
    checkOutput("acc_l0", lane(0), lo16(70));
    @(negedge clk);
    checkOutput("acc_cnt", 32'(beat_cnt), 32'd1);
    checkOutput("acc_drained", 32'(out_valid), 32'd0);

    // Activations
    doBeat(2'b11, 2'b01, 1'b0, -5, 2, 0, "relu_neg");
    doBeat(2'b11, 2'b10, 1'b0, -128, 0, -2, "leaky_128");
    doBeat(2'b11, 2'b10, 1'b0, -1, 0, -1, "leaky_floor");
    doBeat(2'b11, 2'b10, 1'b0, 50, 10, 60, "leaky_pos");
    doBeat(2'b10, 2'b01, 1'b0, -9, 100, 0, "act_relu_psum");
    doBeat(2'b10, 2'b11, 1'b0, -9, 100, -9, "act_rsvd");
    checkOutput("act_no_ovf", 32'(ovf_flag), 32'd0);

    // Saturation, wrap and sticky overflow flags
    doBeat(2'b01, 2'b00, 1'b1, 32767, 1, 32767, "sat_pos");
    checkOutput("sat_pos_ovf", 32'(ovf_flag), 32'hFF);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checkOutput("clr1_ovf", 32'(ovf_flag), 32'd0);
    doBeat(2'b01, 2'b00, 1'b0, 32767, 1, -32768, "wrap_pos");
    checkOutput("wrap_pos_ovf", 32'(ovf_flag), 32'hFF);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checkOutput("clr2_ovf", 32'(ovf_flag), 32'd0);
    doBeat(2'b01, 2'b00, 1'b1, -32768, -1, -32768, "sat_neg");
    checkOutput("sat_neg_ovf", 32'(ovf_flag), 32'hFF);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checkOutput("clr3_ovf", 32'(ovf_flag), 32'd0);

    // Clear coinciding with a new overflow leaves the flag set
    applyStimulus(2'b01, 2'b00, 1'b0, -32768, -1);
    @(negedge clk);
    in_valid  = 1'b0;
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checkOutput("clr_race_ovf", 32'(ovf_flag), 32'hFF);
    checkOutput("wrap_neg_l0", lane(0), lo16(32767));
    @(negedge clk);

    // Back-to-back stream with a three-cycle downstream stall
    doReset();
    out_ready = 1'b1;
    idx = 0;
    oidx = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 60 && oidx < 6; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (idx < 6) begin
        in_valid = 1'b1; mode = 2'b01; act_sel = 2'b00; sat_en = 1'b0;
        psum_in = row_inc(idx * 10);
        ofifo_in = fill(1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready && out_valid && !out_ready) saw_full = 1'b1;
      if (out_valid) begin
        checkOutput("stream_l0", lane(0), 32'(oidx * 10 + 1));
        checkOutput("stream_l7", lane(COL-1), 32'(oidx * 10 + 8));
        if (out_ready) oidx++;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("stream_all_out", 32'(oidx), 32'd6);
    checkOutput("stream_all_in", 32'(idx), 32'd6);
    checkOutput("stream_full_seen", 32'(saw_full), 32'd1);
    checkOutput("stream_cnt", 32'(beat_cnt), 32'd6);
    checkOutput("stream_drained", 32'(out_valid), 32'd0);

    // Pass mode ignores act_sel; a held beat ignores later control changes
    doBeat(2'b00, 2'b01, 1'b0, 3, -7, -7, "pass_noact");
    out_ready = 1'b0;
    applyStimulus(2'b00, 2'b01, 1'b0, 3, -7);
    @(negedge clk);
    in_valid = 1'b0; mode = 2'b11; act_sel = 2'b01; sat_en = 1'b1;
    psum_in = fill(-100); ofifo_in = fill(0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("held_valid", 32'(out_valid), 32'd1);
    checkOutput("held_l0", lane(0), lo16(-7));
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("held_drained", 32'(out_valid), 32'd0);
    checkOutput("held_cnt", 32'(beat_cnt), 32'd8);

    // Reset with two beats in flight
    out_ready = 1'b0;
    applyStimulus(2'b01, 2'b00, 1'b0, 32767, 1);
    @(negedge clk);
    applyStimulus(2'b01, 2'b00, 1'b0, 5, 5);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("flight_valid", 32'(out_valid), 32'd1);
    checkOutput("flight_full", 32'(in_ready), 32'd0);
    checkOutput("flight_ovf", 32'(ovf_flag), 32'hFF);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_ovf", 32'(ovf_flag), 32'd0);
    checkOutput("midrst_cnt", 32'(beat_cnt), 32'd0);
    checkOutput("midrst_data", lane(0), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    checkOutput("midrst_cnt_after", 32'(beat_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
